// File: rtl/ram_sp_240x32_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_sp_240x32_arb_pkg
//   Shared constants and types for the 240x32 single-port SRAM front end.
//
//   Constants : RAM_240_ADR_WD, RAM_240_DAT_WD, RAM_240_DEPTH, RAM_240_FIFO_DEP
//   Types     : gnt_e  - which client was granted last (round-robin memory)
//               arb_e  - grant decision of the current cycle
//   Functions : arb_pick - round-robin choice between the two clients
// ----------------------------------------------------------------------------
package ram_sp_240x32_arb_pkg;

    localparam int RAM_240_ADR_WD   = 8;
    localparam int RAM_240_DAT_WD   = 32;
    localparam int RAM_240_DEPTH    = 240;
    localparam int RAM_240_FIFO_DEP = 3;

    // Last grant holder. Reset value is GNT_RD so the write client wins the
    // first contested cycle.
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_e;

    // Decision for the SRAM port in the current cycle.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WR   = 2'd1,
        ARB_RD   = 2'd2
    } arb_e;

    // Exactly one eligible client is granted; when both are eligible the one
    // that did not win last time gets the port.
    function automatic arb_e arb_pick(input logic wr_elig,
                                      input logic rd_elig,
                                      input gnt_e last);
        arb_e pick;
        pick = ARB_IDLE;
        if (wr_elig && rd_elig) begin
            pick = (last == GNT_RD) ? ARB_WR : ARB_RD;
        end else if (wr_elig) begin
            pick = ARB_WR;
        end else if (rd_elig) begin
            pick = ARB_RD;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ram_sp_240x32_arb_fifo_sync_reg.sv
// ----------------------------------------------------------------------------
// fifo_sync_reg
//   Small register-based synchronous FIFO. Head entry is presented on pop_dat
//   whenever the FIFO is not empty (first-word-fall-through).
//
//   clk       in   clock
//   rst       in   synchronous reset, active-high (clears pointers and count)
//   push      in   write push_dat at the end of this cycle
//   push_dat  in   data to store
//   pop       in   drop the head entry at the end of this cycle
//   pop_dat   out  head entry (meaningful only when !empty)
//   full      out  no free entry
//   empty     out  no stored entry
//   count     out  number of stored entries, 0..DEPTH
//
//   A push while full is only accepted if a pop happens in the same cycle;
//   a push into a full FIFO without a pop is an overflow and is asserted on.
// ----------------------------------------------------------------------------
module fifo_sync_reg #(
    parameter int DEPTH = 3,
    parameter int WD    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WD-1:0]              push_dat,
    input  logic                       pop,
    output logic [WD-1:0]              pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WD = $clog2(DEPTH + 1);

    localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);
    localparam logic [CNT_WD-1:0] CNT_FULL = CNT_WD'(DEPTH);

    logic [WD-1:0]     store_q [DEPTH];
    logic [PTR_WD-1:0] wr_ptr_q;
    logic [PTR_WD-1:0] rd_ptr_q;
    logic [CNT_WD-1:0] cnt_q;

    logic pop_ok;
    logic push_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign count   = cnt_q;
    assign pop_dat = store_q[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && (!full || pop_ok);

    function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_WD'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_WD'(1);
                2'b01:   cnt_q <= cnt_q - CNT_WD'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Data storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop_ok));
        end
    end

endmodule

// File: rtl/ram_sp_240x32_arb.sv
// ----------------------------------------------------------------------------
// ram_sp_240x32_arb
//   Access initiator and arbiter in front of a 240x32 single-port SRAM.
//   A write client and a read client share the single SRAM port, one access
//   per clock. Reads are returned in request order through a small FIFO whose
//   free space is reserved by a credit counter before a read is accepted.
//
//   clk, rst                     clock, synchronous active-high reset
//   wr_val_i/wr_rdy_o            write request handshake
//   wr_adr_i, wr_dat_i           write address / data
//   rd_val_i/rd_rdy_o            read request handshake
//   rd_adr_i                     read address
//   rd_dat_val_o/rd_dat_rdy_i    read return handshake
//   rd_dat_o                     read return data (request order)
//   err_adr_o                    pulse: accepted request had adr >= DEPTH
//   mem_adr_o, mem_wr_ena_o,
//   mem_wr_dat_o, mem_rd_ena_o   SRAM port, driven in the grant cycle
//   mem_rd_dat_i                 SRAM read data, valid the cycle after a read
//
//   Handshakes: every val/rdy pair transfers exactly in the cycles where both
//   val and rdy are 1. rdy of a request port is computed combinationally from
//   the request inputs and registered state and is never 1 during reset;
//   rd_dat_val_o depends only on registered state.
//
//   Timing of a read accepted in cycle N: SRAM read issued in N, data sampled
//   and pushed into the return FIFO at the end of N+1, rd_dat_val_o in N+2.
// ----------------------------------------------------------------------------
module ram_sp_240x32_arb
    import ram_sp_240x32_arb_pkg::*;
#(
    parameter int ADR_WD   = RAM_240_ADR_WD,
    parameter int DAT_WD   = RAM_240_DAT_WD,
    parameter int DEPTH    = RAM_240_DEPTH,
    parameter int FIFO_DEP = RAM_240_FIFO_DEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_val_i,
    output logic              wr_rdy_o,
    input  logic [ADR_WD-1:0] wr_adr_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    input  logic              rd_val_i,
    output logic              rd_rdy_o,
    input  logic [ADR_WD-1:0] rd_adr_i,
    output logic              rd_dat_val_o,
    input  logic              rd_dat_rdy_i,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic              err_adr_o,
    output logic [ADR_WD-1:0] mem_adr_o,
    output logic              mem_wr_ena_o,
    output logic [DAT_WD-1:0] mem_wr_dat_o,
    output logic              mem_rd_ena_o,
    input  logic [DAT_WD-1:0] mem_rd_dat_i
);

    localparam int CNT_WD = $clog2(FIFO_DEP + 1);

    localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(FIFO_DEP);
    localparam logic [ADR_WD-1:0] ADR_LIM = ADR_WD'(DEPTH);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    gnt_e              rr_q;        // last grant holder
    gnt_e              rr_d;
    logic [CNT_WD-1:0] cnt_q;       // reads in flight + FIFO occupancy
    logic [CNT_WD-1:0] cnt_d;
    logic              pend_q;      // a read was issued last cycle
    logic              pend_ill_q;  // ... and its address was illegal

    // ------------------------------------------------------------------
    // Combinational decision for this cycle
    // ------------------------------------------------------------------
    arb_e              arb;
    logic              rd_elig;
    logic              wr_adr_ok;
    logic              rd_adr_ok;
    logic              gnt_wr;
    logic              gnt_rd;
    logic              ret_pop;

    // Return FIFO
    logic [DAT_WD-1:0] fifo_push_dat;
    logic [DAT_WD-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_WD-1:0] fifo_cnt;

    assign wr_adr_ok = (wr_adr_i < ADR_LIM);
    assign rd_adr_ok = (rd_adr_i < ADR_LIM);

    // A read may only be accepted while a FIFO slot is still unreserved.
    assign rd_elig = rd_val_i && (cnt_q < CNT_MAX);

    // Arbiter: next-state and grant outputs.
    always_comb begin
        arb  = ARB_IDLE;
        rr_d = rr_q;
        if (!rst) begin
            arb = arb_pick(wr_val_i, rd_elig, rr_q);
        end
        case (arb)
            ARB_WR:  rr_d = GNT_WR;
            ARB_RD:  rr_d = GNT_RD;
            default: rr_d = rr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= GNT_RD;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign gnt_wr = (arb == ARB_WR);
    assign gnt_rd = (arb == ARB_RD);

    assign wr_rdy_o = gnt_wr;
    assign rd_rdy_o = gnt_rd;

    // SRAM port. Address and write data are forced to 0 without a grant so
    // the macro never sees X. An illegal address is handshaken but gets no
    // enable, so it never touches the array.
    always_comb begin
        mem_adr_o    = '0;
        mem_wr_dat_o = '0;
        mem_wr_ena_o = 1'b0;
        mem_rd_ena_o = 1'b0;
        err_adr_o    = 1'b0;
        if (gnt_wr) begin
            mem_adr_o    = wr_adr_i;
            mem_wr_dat_o = wr_dat_i;
            mem_wr_ena_o = wr_adr_ok;
            err_adr_o    = !wr_adr_ok;
        end else if (gnt_rd) begin
            mem_adr_o    = rd_adr_i;
            mem_rd_ena_o = rd_adr_ok;
            err_adr_o    = !rd_adr_ok;
        end
    end

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_ill_q <= 1'b0;
        end else begin
            pend_q     <= gnt_rd;
            pend_ill_q <= gnt_rd && !rd_adr_ok;
        end
    end

    // An illegal read still occupies its slot in the return order, carrying 0.
    assign fifo_push_dat = pend_ill_q ? '0 : mem_rd_dat_i;

    // Gated by rst so a reset cycle never presents data left in the FIFO.
    assign rd_dat_val_o = !fifo_empty && !rst;
    assign rd_dat_o     = rd_dat_val_o ? fifo_head : '0;
    assign ret_pop      = rd_dat_val_o && rd_dat_rdy_i;

    fifo_sync_reg #(
        .DEPTH (FIFO_DEP),
        .WD    (DAT_WD)
    ) u_ret_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pend_q),
        .push_dat (fifo_push_dat),
        .pop      (ret_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // ------------------------------------------------------------------
    // Credit counter: +1 on read accept, -1 on return pop.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        case ({gnt_rd, ret_pop})
            2'b10:   cnt_d = cnt_q + CNT_WD'(1);
            2'b01:   cnt_d = cnt_q - CNT_WD'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Credits always equal what is outstanding, so a push can never find the
    // FIFO full without a pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt_q == fifo_cnt + CNT_WD'(pend_q));
            assert (!(pend_q && fifo_full && !ret_pop));
            assert (!(mem_wr_ena_o && mem_rd_ena_o));
        end
    end

endmodule

// File: tb/tb_ram_sp_240x32_arb.sv
module tb_ram_sp_240x32_arb;

    localparam int DEPTH = 240;
    localparam int QD    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_val_i, wr_rdy_o, rd_val_i, rd_rdy_o;
    logic [7:0]  wr_adr_i, rd_adr_i, mem_adr_o;
    logic [31:0] wr_dat_i, rd_dat_o, mem_wr_dat_o, mem_rd_dat_i;
    logic        rd_dat_val_o, rd_dat_rdy_i, err_adr_o;
    logic        mem_wr_ena_o, mem_rd_ena_o;

    ram_sp_240x32_arb dut (
        .clk          (clk),
        .rst          (rst),
        .wr_val_i     (wr_val_i),
        .wr_rdy_o     (wr_rdy_o),
        .wr_adr_i     (wr_adr_i),
        .wr_dat_i     (wr_dat_i),
        .rd_val_i     (rd_val_i),
        .rd_rdy_o     (rd_rdy_o),
        .rd_adr_i     (rd_adr_i),
        .rd_dat_val_o (rd_dat_val_o),
        .rd_dat_rdy_i (rd_dat_rdy_i),
        .rd_dat_o     (rd_dat_o),
        .err_adr_o    (err_adr_o),
        .mem_adr_o    (mem_adr_o),
        .mem_wr_ena_o (mem_wr_ena_o),
        .mem_wr_dat_o (mem_wr_dat_o),
        .mem_rd_ena_o (mem_rd_ena_o),
        .mem_rd_dat_i (mem_rd_dat_i)
    );

    // ---------------- SRAM behavioural macro ----------------
    function automatic logic [31:0] seed_val(input int a);
        return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    logic [31:0] sram  [256];
    bit          wrote [256];
    always @(posedge clk) begin
        if (mem_wr_ena_o) begin
            sram[mem_adr_o]  <= mem_wr_dat_o;
            wrote[mem_adr_o] <= 1'b1;
        end
        if (mem_rd_ena_o) begin
            mem_rd_dat_i <= wrote[mem_adr_o] ? sram[mem_adr_o] : seed_val(int'(mem_adr_o));
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Outstanding reads are an ordered list of (data, cycle it becomes visible).
    // Their count is exactly the credit usage of the design.
    logic [31:0] m_mem [256];
    logic [31:0] exp_q [$];
    int          vis_q [$];
    bit          m_last_rd;
    int          cyc = 0;
    bit          e_rd_elig, e_gw, e_gr, e_dval, wlegal, rlegal;
    logic [7:0]  e_adr;

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = seed_val(i);
        m_last_rd = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_wr_rdy", 32'(wr_rdy_o), 0);
                chk("rst_rd_rdy", 32'(rd_rdy_o), 0);
                chk("rst_rd_dat_val", 32'(rd_dat_val_o), 0);
                chk("rst_rd_dat", rd_dat_o, 0);
                chk("rst_err", 32'(err_adr_o), 0);
                chk("rst_mem", {mem_adr_o, 21'd0, mem_wr_ena_o, mem_rd_ena_o}, 0);
                chk("rst_mem_wr_dat", mem_wr_dat_o, 0);
                exp_q.delete();
                vis_q.delete();
                m_last_rd = 1'b1;
            end else begin
                e_rd_elig = rd_val_i && (exp_q.size() < QD);
                e_gw      = wr_val_i && (!e_rd_elig || m_last_rd);
                e_gr      = e_rd_elig && (!wr_val_i || !m_last_rd);
                wlegal    = int'(wr_adr_i) < DEPTH;
                rlegal    = int'(rd_adr_i) < DEPTH;
                e_adr     = e_gw ? wr_adr_i : (e_gr ? rd_adr_i : 8'd0);
                chk("wr_rdy", 32'(wr_rdy_o), 32'(e_gw));
                chk("rd_rdy", 32'(rd_rdy_o), 32'(e_gr));
                chk("mem_wr_ena", 32'(mem_wr_ena_o), 32'(e_gw && wlegal));
                chk("mem_rd_ena", 32'(mem_rd_ena_o), 32'(e_gr && rlegal));
                chk("err_adr", 32'(err_adr_o), 32'((e_gw && !wlegal) || (e_gr && !rlegal)));
                chk("mem_adr", 32'(mem_adr_o), 32'(e_adr));
                chk("mem_wr_dat", mem_wr_dat_o, e_gw ? wr_dat_i : 32'd0);
                e_dval = (exp_q.size() > 0) && (vis_q[0] <= cyc);
                chk("rd_dat_val", 32'(rd_dat_val_o), 32'(e_dval));
                if (e_dval) chk("rd_dat", rd_dat_o, exp_q[0]);
                // advance model to the next cycle
                if (e_dval && rd_dat_rdy_i) begin
                    void'(exp_q.pop_front());
                    void'(vis_q.pop_front());
                end
                if (e_gw) begin
                    if (wlegal) m_mem[wr_adr_i] = wr_dat_i;
                    m_last_rd = 1'b0;
                end
                if (e_gr) begin
                    exp_q.push_back(rlegal ? m_mem[rd_adr_i] : 32'd0);
                    vis_q.push_back(cyc + 2);
                    m_last_rd = 1'b1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic        s_wr_rdy, s_rd_rdy, s_dval, s_err, s_mwe, s_mre;
    logic [31:0] s_dat;

    task automatic step(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [7:0] ra, input logic dr);
        wr_val_i = wv; wr_adr_i = wa; wr_dat_i = wd;
        rd_val_i = rv; rd_adr_i = ra; rd_dat_rdy_i = dr;
        #3;
        s_wr_rdy = wr_rdy_o; s_rd_rdy = rd_rdy_o; s_dval = rd_dat_val_o;
        s_dat = rd_dat_o; s_err = err_adr_o; s_mwe = mem_wr_ena_o; s_mre = mem_rd_ena_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int          acc, extra, run, max_run, exp_idx, wacc;
    logic [5:0]  pat;
    logic [7:0]  a;

    initial begin
        wr_val_i = 0; wr_adr_i = 0; wr_dat_i = 0;
        rd_val_i = 0; rd_adr_i = 0; rd_dat_rdy_i = 1;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_dval_literal", 32'(s_dval), 0);

        // 1: write then read back
        step(1'b1, 8'd5, 32'hDEAD_BEEF, 1'b0, 8'd0, 1'b1);
        chk("s1_wr_acc", 32'(s_wr_rdy), 1);
        step(1'b0, 8'd0, 32'd0, 1'b1, 8'd5, 1'b1);
        chk("s1_rd_acc", 32'(s_rd_rdy), 1);
        idle(1);
        chk("s1_dval_n1", 32'(s_dval), 0);
        idle(1);
        chk("s1_dval_n2", 32'(s_dval), 1);
        chk("s1_dat", s_dat, 32'hDEAD_BEEF);

        // 2: contested port alternates starting with write
        do_reset();
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom_range(0, 239)), $urandom, 1'b1, 8'($urandom_range(0, 239)), 1'b1);
            pat = {pat[4:0], s_wr_rdy};
            chk("s2_onehot_grant", 32'(s_wr_rdy ^ s_rd_rdy), 1);
            chk("s2_no_both_ena", 32'(s_mwe & s_mre), 0);
        end
        chk("s2_pattern", 32'(pat), 32'h2A);
        idle(4);

        // 3: backpressure limits accepts to the FIFO depth
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'd0, 32'd0, 1'b1, 8'($urandom_range(0, 239)), 1'b0);
            if (s_rd_rdy) acc++;
        end
        chk("s3_accepts", 32'(acc), 3);
        chk("s3_last_rdy", 32'(s_rd_rdy), 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'd0, 32'd0, 1'(extra < 2), 8'($urandom_range(0, 239)), 1'b1);
            if (s_rd_rdy) extra++;
        end
        chk("s3_remaining", 32'(extra), 2);
        idle(4);

        // 4: illegal addresses
        step(1'b0, 8'd0, 32'd0, 1'b1, 8'd240, 1'b1);
        chk("s4_rd_acc", 32'(s_rd_rdy), 1);
        chk("s4_rd_err", 32'(s_err), 1);
        chk("s4_rd_no_ena", 32'(s_mre), 0);
        step(1'b1, 8'd255, 32'hFFFF_FFFF, 1'b0, 8'd0, 1'b1);
        chk("s4_wr_acc", 32'(s_wr_rdy), 1);
        chk("s4_wr_err", 32'(s_err), 1);
        chk("s4_wr_no_ena", 32'(s_mwe), 0);
        idle(1);
        chk("s4_ret_val", 32'(s_dval), 1);
        chk("s4_ret_zero", s_dat, 0);
        idle(3);

        // 5: fill and stream back-to-back
        wacc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 32'(i), 1'b0, 8'd0, 1'b1);
            if (s_wr_rdy) wacc++;
        end
        chk("s5_writes", 32'(wacc), DEPTH);
        acc = 0; run = 0; max_run = 0; exp_idx = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            a = 8'(i);
            step(1'b0, 8'd0, 32'd0, 1'(i < DEPTH), a, 1'b1);
            if (s_rd_rdy) acc++;
            if (s_dval) begin
                chk("s5_data", s_dat, 32'(exp_idx));
                exp_idx++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        chk("s5_accepts", 32'(acc), DEPTH);
        chk("s5_run", 32'(max_run), DEPTH);

        // 6: reset right after a read accept drops it
        step(1'b0, 8'd0, 32'd0, 1'b1, 8'd7, 1'b1);
        chk("s6_rd_acc", 32'(s_rd_rdy), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("s6_no_dval", 32'(s_dval), 0);
        end
        step(1'b0, 8'd0, 32'd0, 1'b1, 8'd5, 1'b1);
        chk("s6_rd_acc2", 32'(s_rd_rdy), 1);
        idle(1);
        chk("s6_dval_n1", 32'(s_dval), 0);
        idle(1);
        chk("s6_dval_n2", 32'(s_dval), 1);
        chk("s6_dat", s_dat, 32'd5);
        idle(2);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'd0, 32'd0, 1'b1, 8'($urandom_range(0, 239)), 1'b0);
            if (s_rd_rdy) acc++;
        end
        chk("s6_credits_full", 32'(acc), 3);
        idle(5);

        // random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 239)),
                 $urandom,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 239)),
                 1'($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
